nbit_register: RTL and testbench



---
 rtl/nbit_register_pkg.sv | 12 +
 rtl/nbit_register.sv | 53 +++++
 tb/tb_nbit_register.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/nbit_register_pkg.sv
// Shared FunSel encoding for register-based datapath blocks.
// Pure type/constant package; no logic, latency or backpressure.
package nbit_register_pkg;

    typedef logic [1:0] funsel_t;

    localparam funsel_t FUNSEL_CLEAR = 2'b00;
    localparam funsel_t FUNSEL_LOAD  = 2'b01;
    localparam funsel_t FUNSEL_DEC   = 2'b10;
    localparam funsel_t FUNSEL_INC   = 2'b11;

endpackage

// File: rtl/nbit_register.sv
// N-bit register with clear/load/decrement/increment, wrapping modulo 2^NBits.
// One-clock latency; no backpressure, e=0 simply holds the contents.
module nbit_register
    import nbit_register_pkg::*;
#(
    parameter int NBits = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  funsel_t          funsel,
    input  logic             e,
    input  logic [NBits-1:0] i,
    output logic [NBits-1:0] q
);

    localparam logic [NBits-1:0] ONE = NBits'(1);

    logic [NBits-1:0] q_q;
    logic [NBits-1:0] q_d;

    // i is only consulted on load, so an unknown i cannot leak into other ops.
    always_comb begin
        q_d = q_q;
        if (e) begin
            case (funsel)
                FUNSEL_CLEAR: q_d = '0;
                FUNSEL_LOAD:  q_d = i;
                FUNSEL_DEC:   q_d = q_q - ONE;
                FUNSEL_INC:   q_d = q_q + ONE;
                default:      q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

    a_hold_when_disabled: assert property (
        @(posedge clk) disable iff (!rst_n) !e |=> $stable(q_q)
    );

    a_zero_in_reset: assert property (
        @(posedge clk) !rst_n |-> (q_q == '0)
    );

endmodule

// File: tb/tb_nbit_register.sv
// Directed bench for nbit_register at NBits=4 and NBits=8.
module tb_nbit_register;
    import nbit_register_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    funsel_t    fs4, fs8;
    logic       e4, e8;
    logic [3:0] i4, q4;
    logic [7:0] i8, q8;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nbit_register #(.NBits(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .funsel(fs4),
        .e     (e4),
        .i     (i4),
        .q     (q4)
    );

    nbit_register dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .funsel(fs8),
        .e     (e8),
        .i     (i8),
        .q     (q8)
    );

    task automatic chk4(input string tag, input logic [3:0] exp);
        vectors++;
        assert (q4 === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, q4, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] exp);
        vectors++;
        assert (q8 === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, q8, exp);
        end
    endtask

    task automatic op4(input funsel_t f, input logic en, input logic [3:0] d);
        fs4 = f;
        e4  = en;
        i4  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input funsel_t f, input logic en, input logic [7:0] d);
        fs8 = f;
        e8  = en;
        i8  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ld_vals [5];
        logic [3:0] exp4;
        ld_vals = '{4'b1111, 4'b1010, 4'b0001, 4'b0110, 4'b0000};

        rst_n = 1'b0;
        fs4 = FUNSEL_CLEAR; e4 = 1'b0; i4 = '0;
        fs8 = FUNSEL_CLEAR; e8 = 1'b0; i8 = '0;
        #12;
        chk4("reset_q4", 4'b0000);
        chk8("reset_q8", 8'h00);

        // Reset must win over an enabled increment edge.
        op4(FUNSEL_INC, 1'b1, 4'b0000);
        chk4("reset_dominates_edge", 4'b0000);
        rst_n = 1'b1;
        e4    = 1'b0;
        @(posedge clk);
        #1;
        chk4("after_release", 4'b0000);

        foreach (ld_vals[k]) begin
            op4(FUNSEL_LOAD, 1'b1, ld_vals[k]);
            chk4("load", ld_vals[k]);
            op4(FUNSEL_CLEAR, 1'b1, 4'b1111);
            chk4("clear", 4'b0000);
        end

        op4(FUNSEL_LOAD, 1'b1, 4'b1001);
        op4(FUNSEL_CLEAR, 1'b1, 4'b0000);
        chk4("inc_pre_clear", 4'b0000);
        exp4 = 4'b0000;
        for (int k = 1; k <= 17; k++) begin
            op4(FUNSEL_INC, 1'b1, 4'b0000);
            exp4 = exp4 + 4'd1;
            chk4("inc_wrap", exp4);
        end

        op4(FUNSEL_CLEAR, 1'b1, 4'b0000);
        chk4("dec_pre_clear", 4'b0000);
        exp4 = 4'b0000;
        for (int k = 1; k <= 17; k++) begin
            op4(FUNSEL_DEC, 1'b1, 4'b0000);
            exp4 = exp4 - 4'd1;
            chk4("dec_wrap", exp4);
        end

        op4(FUNSEL_LOAD, 1'b1, 4'b0101);
        chk4("gate_load", 4'b0101);
        for (int k = 0; k < 8; k++) begin
            op4(funsel_t'(k % 4), 1'b0, 4'b1010);
            chk4("gate_hold", 4'b0101);
        end
        op4(FUNSEL_INC, 1'b1, 4'b1010);
        chk4("gate_resume_inc", 4'b0110);

        op4(FUNSEL_LOAD, 1'b1, 4'b1010);
        op4(FUNSEL_INC, 1'b1, 4'b0000);
        chk4("pre_reset_count", 4'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        chk4("async_reset_q4", 4'b0000);
        chk8("async_reset_q8", 8'h00);
        #1;
        rst_n = 1'b1;
        op4(FUNSEL_INC, 1'b1, 4'b0000);
        chk4("inc_after_reset", 4'b0001);

        op4(FUNSEL_LOAD, 1'b1, 4'b0011);
        op4(FUNSEL_INC, 1'b1, 4'b0000);
        op4(FUNSEL_CLEAR, 1'b1, 4'b0000);
        chk4("back_to_back", 4'b0000);
        e4 = 1'b0;

        op8(FUNSEL_LOAD, 1'b1, 8'hFF);
        chk8("w8_load_ff", 8'hFF);
        op8(FUNSEL_INC, 1'b1, 8'h00);
        chk8("w8_inc_wrap", 8'h00);
        op8(FUNSEL_LOAD, 1'b1, 8'h80);
        chk8("w8_load_80", 8'h80);
        op8(FUNSEL_DEC, 1'b1, 8'h00);
        chk8("w8_dec", 8'h7F);
        op8(FUNSEL_DEC, 1'b0, 8'h00);
        chk8("w8_hold", 8'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
